stream_capture: RTL and testbench

STREAM_CAPTURE -- requirements
Module: stream_capture

---
 rtl/stream_capture.sv | 172 +++++++++++++++++
 tb/tb_stream_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_capture.sv
// -----------------------------------------------------------------------------
// stream_capture
//
// Triggered capture of a sample stream into a circular buffer. An arm pulse
// starts a capture. Kept samples are written continuously and the oldest
// history is overwritten. The first kept sample seen while trigger is high is
// the trigger sample. After it, post_count further kept samples are stored
// and the block then parks in DONE until it is armed again. The buffer can be
// read at any time through a registered read port.
//
// Parameters
//   DATA_WIDTH  - sample width in bits
//   ADDR_WIDTH  - buffer address width (depth = 2**ADDR_WIDTH)
//   DECIM_WIDTH - width of the decimation ratio
//
// Ports
//   test_clock    in   sole clock, rising edge
//   test_reset_n  in   asynchronous active-low reset
//   stream_in     in   sample data
//   stream_valid  in   stream_in valid this cycle
//   arm           in   single-cycle pulse, (re)start capture
//   trigger       in   trigger level, qualified by a kept sample
//   decimation    in   keep 1 of every decimation+1 valid samples (sampled at arm)
//   post_count    in   samples stored after the trigger sample (sampled at trigger)
//   rd_addr       in   buffer read address
//   rd_data       out  buffer[rd_addr], one cycle latency, read-before-write
//   state         out  00 IDLE, 01 ARMED, 10 POST, 11 DONE
//   trig_addr     out  buffer address of the trigger sample
//   done          out  high while in DONE
// -----------------------------------------------------------------------------
module stream_capture #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DECIM_WIDTH = 16
) (
    input  logic                   test_clock,
    input  logic                   test_reset_n,
    input  logic [DATA_WIDTH-1:0]  stream_in,
    input  logic                   stream_valid,
    input  logic                   arm,
    input  logic                   trigger,
    input  logic [DECIM_WIDTH-1:0] decimation,
    input  logic [ADDR_WIDTH-1:0]  post_count,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [1:0]             state,
    output logic [ADDR_WIDTH-1:0]  trig_addr,
    output logic                   done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = 1;
    localparam logic [DECIM_WIDTH-1:0] DECIM_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t                  state_reg,       state_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg,      wr_ptr_next;
    logic [DECIM_WIDTH-1:0]  decim_cnt_reg,   decim_cnt_next;
    logic [DECIM_WIDTH-1:0]  decim_ratio_reg, decim_ratio_next;
    logic [ADDR_WIDTH-1:0]   post_cnt_reg,    post_cnt_next;
    logic [ADDR_WIDTH-1:0]   trig_addr_reg,   trig_addr_next;
    logic [DATA_WIDTH-1:0]   rd_data_reg;

    logic capturing;
    logic sample_kept;
    logic wr_en;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // A sample presented in the same cycle as arm belongs to the old capture
    // and is dropped; the restarted capture begins on the following cycle.
    assign capturing   = (state_reg == ST_ARMED) || (state_reg == ST_POST);
    assign sample_kept = capturing && stream_valid && !arm && (decim_cnt_reg == '0);

    // Once the post counter has run out, POST spends one more cycle before
    // DONE and must not write during it.
    assign wr_en = sample_kept && !((state_reg == ST_POST) && (post_cnt_reg == '0));

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        decim_cnt_next   = decim_cnt_reg;
        decim_ratio_next = decim_ratio_reg;
        post_cnt_next    = post_cnt_reg;
        trig_addr_next   = trig_addr_reg;

        if (arm) begin
            // arm wins over trigger and restarts from any state
            state_next       = ST_ARMED;
            wr_ptr_next      = '0;
            decim_cnt_next   = '0;
            decim_ratio_next = decimation;
        end else begin
            if (capturing && stream_valid) begin
                if (decim_cnt_reg == decim_ratio_reg) begin
                    decim_cnt_next = '0;
                end else begin
                    decim_cnt_next = decim_cnt_reg + DECIM_ONE;
                end
            end

            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + ADDR_ONE;
            end

            case (state_reg)
                ST_ARMED: begin
                    if (sample_kept && trigger) begin
                        trig_addr_next = wr_ptr_reg;
                        post_cnt_next  = post_count;
                        state_next     = ST_POST;
                    end
                end
                ST_POST: begin
                    if (post_cnt_reg == '0) begin
                        state_next = ST_DONE;
                    end else if (wr_en) begin
                        post_cnt_next = post_cnt_reg - ADDR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge test_clock or negedge test_reset_n) begin
        if (!test_reset_n) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            decim_cnt_reg   <= '0;
            decim_ratio_reg <= '0;
            post_cnt_reg    <= '0;
            trig_addr_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            decim_cnt_reg   <= decim_cnt_next;
            decim_ratio_reg <= decim_ratio_next;
            post_cnt_reg    <= post_cnt_next;
            trig_addr_reg   <= trig_addr_next;
        end
    end

    // Buffer array: not reset so it maps onto block RAM.
    always_ff @(posedge test_clock) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= stream_in;
        end
    end

    // Registered read; a same-cycle write to rd_addr yields the old word.
    always_ff @(posedge test_clock or negedge test_reset_n) begin
        if (!test_reset_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data   = rd_data_reg;
    assign state     = state_reg;
    assign trig_addr = trig_addr_reg;
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_stream_capture.sv
// -----------------------------------------------------------------------------
// tb_stream_capture
//
// Self-checking bench for stream_capture with a 16-word buffer. Inputs are
// driven and outputs sampled 1 ns after the rising edge. Buffer readback
// pushes the expected word when an address is presented and pops it when the
// registered read data appears.
// -----------------------------------------------------------------------------
module tb_stream_capture;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int XW = 8;
    localparam int DEPTH = 16;

    logic          test_clock = 1'b0;
    logic          test_reset_n;
    logic [DW-1:0] stream_in;
    logic          stream_valid;
    logic          arm;
    logic          trigger;
    logic [XW-1:0] decimation;
    logic [AW-1:0] post_count;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [1:0]    state;
    logic [AW-1:0] trig_addr;
    logic          done;

    int test_count = 0;
    int fail_count = 0;
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    stream_capture #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DECIM_WIDTH(XW)
    ) dut (
        .test_clock  (test_clock),
        .test_reset_n(test_reset_n),
        .stream_in   (stream_in),
        .stream_valid(stream_valid),
        .arm         (arm),
        .trigger     (trigger),
        .decimation  (decimation),
        .post_count  (post_count),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .state       (state),
        .trig_addr   (trig_addr),
        .done        (done)
    );

    always #5 test_clock = ~test_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish before it");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    task automatic step();
        @(posedge test_clock);
        #1;
    endtask

    task automatic send(input logic v, input logic [DW-1:0] d, input logic a, input logic t);
        stream_valid = v;
        stream_in    = d;
        arm          = a;
        trigger      = t;
        step();
    endtask

    task automatic idle_inputs();
        stream_valid = 1'b0;
        arm          = 1'b0;
        trigger      = 1'b0;
    endtask

    // Read all addresses; rd_addr is moved away right after each edge so a
    // combinational read path would show the wrong word.
    task automatic read_all(input string tag);
        logic [DW-1:0] exp;
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            exp_q.push_back(exp_mem[a]);
            step();
            rd_addr = AW'((a + 7) % DEPTH);
            #1;
            exp = exp_q.pop_front();
            check_value($sformatf("%s[%0d]", tag, a), 32'(rd_data), 32'(exp));
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        test_reset_n = 1'b0;
        stream_in    = '0;
        stream_valid = 1'b0;
        arm          = 1'b0;
        trigger      = 1'b0;
        decimation   = '0;
        post_count   = '0;
        rd_addr      = '0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check_value("rst_state", 32'(state), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_trig_addr", 32'(trig_addr), 32'd0);
        check_value("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge test_clock);
        test_reset_n = 1'b1;
        step();
        check_value("idle_state", 32'(state), 32'd0);

        // ---------------- basic capture ----------------
        decimation = 8'd0;
        post_count = 4'd3;
        send(1'b0, '0, 1'b1, 1'b0);
        check_value("basic_armed", 32'(state), 32'd1);
        for (int n = 0; n < 100; n++) send(1'b1, DW'(n), 1'b0, 1'b0);
        send(1'b1, DW'(100), 1'b0, 1'b1);
        check_value("basic_post", 32'(state), 32'd2);
        check_value("basic_trig_addr", 32'(trig_addr), 32'd4);
        for (int n = 101; n <= 103; n++) send(1'b1, DW'(n), 1'b0, 1'b0);
        check_value("basic_still_post", 32'(state), 32'd2);
        check_value("basic_not_done", 32'(done), 32'd0);
        send(1'b1, DW'(104), 1'b0, 1'b0);
        check_value("basic_done_state", 32'(state), 32'd3);
        check_value("basic_done", 32'(done), 32'd1);
        for (int n = 105; n <= 110; n++) send(1'b1, DW'(n), 1'b0, 1'b1);
        check_value("basic_done_hold", 32'(state), 32'd3);
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = DW'(103 - ((103 - a) % DEPTH));
        read_all("basic_buf");

        // ---------------- decimation ----------------
        decimation = 8'd3;
        post_count = 4'd2;
        send(1'b0, '0, 1'b1, 1'b0);
        decimation = 8'd0;   // must not affect this capture
        for (int n = 0; n <= 40; n++) send(1'b1, DW'(n), 1'b0, 1'b0);
        send(1'b1, DW'(41), 1'b0, 1'b1);
        check_value("decim_trig_ignored", 32'(state), 32'd1);
        send(1'b1, DW'(42), 1'b0, 1'b1);
        send(1'b1, DW'(43), 1'b0, 1'b1);
        check_value("decim_still_armed", 32'(state), 32'd1);
        send(1'b1, DW'(44), 1'b0, 1'b1);
        check_value("decim_post", 32'(state), 32'd2);
        check_value("decim_trig_addr", 32'(trig_addr), 32'd11);
        post_count = 4'd9;   // must not affect this capture
        for (int n = 45; n <= 52; n++) send(1'b1, DW'(n), 1'b0, 1'b0);
        check_value("decim_last_post", 32'(state), 32'd2);
        send(1'b1, DW'(53), 1'b0, 1'b0);
        check_value("decim_done", 32'(done), 32'd1);
        for (int a = 0; a < DEPTH; a++)
            exp_mem[a] = (a <= 13) ? DW'(4 * a) : DW'(103 - ((103 - a) % DEPTH));
        read_all("decim_buf");

        // ---------------- wrap + read-before-write ----------------
        decimation = 8'd0;
        post_count = 4'd5;
        send(1'b0, '0, 1'b1, 1'b0);
        for (int n = 0; n < 16; n++) send(1'b1, DW'(16'h100 + n), 1'b0, 1'b0);
        for (int n = 16; n <= 19; n++) begin
            rd_addr = AW'(n % DEPTH);
            send(1'b1, DW'(16'h100 + n), 1'b0, (n == 19));
            check_value($sformatf("rbw_addr%0d", n % DEPTH), 32'(rd_data), 32'(16'h100 + n - 16));
        end
        check_value("wrap_trig_addr", 32'(trig_addr), 32'd3);
        post_count = 4'd0;   // must not affect this capture
        for (int n = 20; n <= 24; n++) send(1'b1, DW'(16'h100 + n), 1'b0, 1'b0);
        send(1'b1, DW'(16'h100 + 25), 1'b0, 1'b0);
        check_value("wrap_done", 32'(state), 32'd3);
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = DW'(16'h100 + 24 - ((24 - a) % DEPTH));
        read_all("wrap_buf");

        // ---------------- edge cases ----------------
        post_count = 4'd0;
        send(1'b0, '0, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) send(1'b1, DW'(n), 1'b0, 1'b0);
        send(1'b1, DW'(5), 1'b0, 1'b1);
        check_value("pc0_post", 32'(state), 32'd2);
        check_value("pc0_trig_addr", 32'(trig_addr), 32'd5);
        send(1'b1, DW'(6), 1'b0, 1'b0);
        check_value("pc0_done", 32'(state), 32'd3);
        send(1'b1, DW'(0), 1'b1, 1'b1);
        check_value("arm_in_done_state", 32'(state), 32'd1);
        check_value("arm_in_done_trig", 32'(trig_addr), 32'd5);
        for (int n = 0; n < 3; n++) send(1'b1, DW'(n), 1'b0, 1'b0);
        send(1'b1, DW'(3), 1'b1, 1'b1);
        check_value("arm_trig_same_state", 32'(state), 32'd1);
        check_value("arm_trig_same_taddr", 32'(trig_addr), 32'd5);
        send(1'b1, DW'(7), 1'b0, 1'b1);
        check_value("rearm_ptr0_trig", 32'(trig_addr), 32'd0);
        check_value("rearm_ptr0_post", 32'(state), 32'd2);
        send(1'b0, '0, 1'b0, 1'b0);
        check_value("rearm_done", 32'(done), 32'd1);

        // ---------------- reset mid-POST ----------------
        post_count = 4'd10;
        rd_addr    = 4'd2;
        send(1'b0, '0, 1'b1, 1'b0);
        for (int n = 0; n <= 5; n++) begin
            d = DW'(16'h200 + n);
            send(1'b1, d, 1'b0, (n == 3));
        end
        check_value("pre_rst_state", 32'(state), 32'd2);
        check_value("pre_rst_rd_data", 32'(rd_data), 32'h202);
        @(negedge test_clock);
        #2;
        test_reset_n = 1'b0;
        #1;
        check_value("mid_rst_state", 32'(state), 32'd0);
        check_value("mid_rst_done", 32'(done), 32'd0);
        check_value("mid_rst_trig_addr", 32'(trig_addr), 32'd0);
        check_value("mid_rst_rd_data", 32'(rd_data), 32'd0);
        idle_inputs();
        @(negedge test_clock);
        test_reset_n = 1'b1;
        send(1'b0, '0, 1'b1, 1'b0);
        check_value("post_rst_arm", 32'(state), 32'd1);
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
